if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/if_prefetch_queue.sv | 77 +++++++
 tb/tb_if_prefetch_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: a circular buffer of {pc+4, instr} between fetch and decode.
// Flush and reset empty it; push and pop update the queue on the rising clock edge with no fall-through path.
module if_prefetch_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          fetch_pc,
  input  logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_ready,
  input  logic                       id_ready,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_instruction,
  output logic [ADDR_W-1:0]          id_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pc4_mem   [DEPTH];
  logic [DATA_W-1:0] r_instr_mem [DEPTH];

  logic w_not_full;
  logic w_not_empty;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers derive from registered occupancy only; flush gates both.
  assign w_not_full  = (r_count != CNT_W'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = fetch_valid && w_not_full && !flush;
  assign w_pop       = w_not_empty && id_ready && !flush;

  // Pointer and occupancy state; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is written only on an accepted push; pc+4 is precomputed so the head path is a plain read.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pc4_mem[r_wr_ptr]   <= ADDR_W'(fetch_pc + ADDR_W'(4));
      r_instr_mem[r_wr_ptr] <= fetch_instr;
    end
  end

  assign fetch_ready    = w_not_full;
  assign id_valid       = w_not_empty;
  assign count          = r_count;
  assign id_instruction = w_not_empty ? r_instr_mem[r_rd_ptr] : '0;
  assign id_pc_plus_4   = w_not_empty ? r_pc4_mem[r_rd_ptr]   : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus random traffic, checked every cycle against a queue model.
module tb_if_prefetch_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_ready;
  logic              id_ready;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_instruction;
  logic [ADDR_W-1:0] id_pc_plus_4;
  logic [CNT_W-1:0]  count;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_ready(fetch_ready), .id_ready(id_ready),
    .flush(flush), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc_plus_4(id_pc_plus_4), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_model();
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc4;
    e_instr = '0;
    e_pc4   = '0;
    if (q.size() != 0) begin
      e_instr = q[0].instr;
      e_pc4   = ADDR_W'(q[0].pc + ADDR_W'(4));
    end
    check("count",          64'(count),          64'(q.size()));
    check("fetch_ready",    64'(fetch_ready),    64'(q.size() != DEPTH));
    check("id_valid",       64'(id_valid),       64'(q.size() != 0));
    check("id_instruction", 64'(id_instruction), 64'(e_instr));
    check("id_pc_plus_4",   64'(id_pc_plus_4),   64'(e_pc4));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the following falling edge.
  task automatic cycle(input logic a_rst, input logic a_fv, input logic [ADDR_W-1:0] a_pc,
                       input logic [DATA_W-1:0] a_ins, input logic a_idr, input logic a_fl);
    int  n;
    rst = a_rst; fetch_valid = a_fv; fetch_pc = a_pc; fetch_instr = a_ins;
    id_ready = a_idr; flush = a_fl;
    @(posedge clk);
    n = q.size();
    if (a_rst || a_fl) begin
      q.delete();
    end else begin
      if (n != 0 && a_idr) void'(q.pop_front());
      if (a_fv && n != DEPTH) q.push_back('{pc: a_pc, instr: a_ins});
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic a_idr);
    cycle(1'b0, 1'b0, '0, '0, a_idr, 1'b0);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a_pc, input logic [DATA_W-1:0] a_ins);
    cycle(1'b0, 1'b1, a_pc, a_ins, 1'b0, 1'b0);
  endtask

  initial begin
    logic [ADDR_W-1:0] drain_exp [3];
    drain_exp[0] = 32'h8; drain_exp[1] = 32'hC; drain_exp[2] = 32'h10;
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0; id_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h100, 32'hAAAA, 1'b1, 1'b1);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    check("rst_id_valid",    64'(id_valid),    64'd0);
    check("rst_instr",       64'(id_instruction), 64'd0);
    check("rst_pc4",         64'(id_pc_plus_4),   64'd0);

    // Fill while decode is frozen, then drain.
    for (int i = 0; i < 4; i++) push(ADDR_W'(i * 4), DATA_W'(32'h1000 + i));
    check("fill_count", 64'(count), 64'd4);
    check("fill_ready", 64'(fetch_ready), 64'd0);
    idle(1'b0);
    check("freeze_pc4", 64'(id_pc_plus_4), 64'h4);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("drain_pc4", 64'(id_pc_plus_4), 64'(drain_exp[i]));
    end
    idle(1'b1);
    check("drain_empty", 64'(id_valid), 64'd0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    push(32'h200, 32'h2000);
    push(32'h204, 32'h2001);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, ADDR_W'(32'h208 + i * 4), DATA_W'(32'h2002 + i), 1'b1, 1'b0);
      check("steady_count", 64'(count), 64'd2);
    end

    // Flush with simultaneous push and pop at count 3.
    push(32'h300, 32'h3000);
    check("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b0, 1'b1, 32'h304, 32'hDEAD, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(id_valid), 64'd0);
    check("flush_instr", 64'(id_instruction), 64'd0);
    idle(1'b0);
    check("flush_stays_empty", 64'(id_valid), 64'd0);

    // Full with pop: pop taken, push refused.
    for (int i = 0; i < 4; i++) push(ADDR_W'(32'h400 + i * 4), DATA_W'(32'h4000 + i));
    cycle(1'b0, 1'b1, 32'h410, 32'hBEEF, 1'b1, 1'b0);
    check("full_pop_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("full_pop_no_push", 64'(id_valid), 64'd0);

    // pc+4 wraps to zero.
    push(32'hFFFF_FFFC, 32'h5000);
    check("wrap_valid", 64'(id_valid), 64'd1);
    check("wrap_pc4", 64'(id_pc_plus_4), 64'h0);
    idle(1'b1);

    // Reset mid-stream while pushing.
    push(32'h600, 32'h6000);
    push(32'h604, 32'h6001);
    cycle(1'b1, 1'b1, 32'h608, 32'h6002, 1'b0, 1'b0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_ready", 64'(fetch_ready), 64'd1);
    check("midrst_valid", 64'(id_valid), 64'd0);
    push(32'h40, 32'h7000);
    check("post_rst_pc4", 64'(id_pc_plus_4), 64'h44);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 70),
            ADDR_W'($urandom) & ~ADDR_W'(3), DATA_W'($urandom),
            ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
